core_mul_seq: RTL and testbench
===============================

# core_mul_seq

Parametrised, multi-cycle signed/unsigned multiply-accumulate unit for the core's MUL/MLA/UMULL/UMLAL/SMULL/SMLAL execution path. It computes q = a * b (+ c) with a radix-2 Booth recurrence, one step per clock, behind an explicit start/done handshake. It also produces the Z and N flags; C and V are not produced and stay unaffected. It sits beside the ALU in the execute stage and stalls the pipeline through `busy`.

## Interface
Parameters:
- `W`, 32, operand word width; must be ≥ 4.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while idle.
- `a`, `b`  in  W  multiplicand and multiplier.
- `c_hi`, `c_lo`  in  W  accumulate addend; `c_hi` is used only when `c_size`=1.
- `c_size`  in  1  1 means c is 2W bits; 0 means c is `c_lo` extended per `sig`.
- `add`  in  1  1 means add c; 0 means no accumulate.
- `sig`  in  1  1 means signed operands; 0 means unsigned.
- `q_size`  in  1  1 means the result is 2W bits; 0 means only `q_lo` is significant.
- `q_hi`, `q_lo`  out  W  result.
- `z`, `n`  out  1  zero and negative flags of the result.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse when q, z and n are valid.

## Operation
- States: IDLE, MUL, ACC, DONE.
- **IDLE**
  - With `start`=1 at a rising edge, all inputs are latched and the FSM goes to MUL.
  - Inputs may change freely after that edge.
- **Operand extension**
  - `a` and `b` are extended to W+1 bits: sign-extended when `sig`=1, zero-extended when `sig`=0.
  - A single signed Booth datapath then covers both modes.
- **MUL**
  - Step counter starts at W+1 and decrements once per cycle.
  - Each step looks at the pair {multiplier LSB, previous bit}:
    - 01: add the multiplicand to the upper accumulator.
    - 10: subtract the multiplicand from the upper accumulator.
    - 00 or 11: no change.
  - Every step ends with a 1-bit arithmetic right shift.
  - When the counter reaches 0, the FSM goes to ACC if the latched `add`=1, otherwise to DONE.
  - The product is the low 2W bits of the accumulator.
- **ACC**
  - Adds c, modulo 2^(2W).
  - With `c_size`=1, c = {c_hi, c_lo}.
  - With `c_size`=0, c = `c_lo` sign-extended when `sig`=1, zero-extended when `sig`=0.
- **DONE**
  - `q_hi`/`q_lo` are registered.
  - With `q_size`=0, `q_hi` reads 0.
  - Flags: `z` = (`q_size` ? {q_hi,q_lo} : q_lo) == 0; `n` = `q_size` ? `q_hi[W-1]` : `q_lo[W-1]`.
  - Unconditionally returns to IDLE the next cycle.
- Outputs `q_hi`, `q_lo`, `z` and `n` hold until the next `done`.
- `start` while `busy`=1 is ignored; it is not queued.
- `start`=1 in the cycle `done`=1 is accepted, because the FSM is in IDLE on that edge.

## Timing
- Reset values: `q_hi`=`q_lo`=0, `z`=0, `n`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- `rst_n` low at any time, including mid-operation, aborts the operation and forces the reset values. No `done` is produced for the aborted operation.
- Let `start` be sampled at edge t:
  - `busy`=1 from edge t until the edge that raises `done`.
  - Without accumulate, `done`=1 for exactly one cycle after edge t+W+2.
  - With accumulate, `done`=1 for exactly one cycle after edge t+W+3.
- Back-to-back issue: the next start edge can be the edge that ends `done`. Throughput is one op per W+3 cycles, or W+4 with accumulate.
- There is no combinational path from any input to any output.

## Configuration
- `CORE_MUL_ACC_EN` defined: the ACC state and the c adder exist, and `add`, `c_size`, `c_hi` and `c_lo` are honoured.
- Undefined: the ports remain but are ignored, ACC is never entered, and latency is always W+2.

## Structure
- `core_mul_pkg` holds:
  - the `mul_state_t` enum (IDLE, MUL, ACC, DONE);
  - the `CORE_MUL_CNT_W` = $clog2(W+2) function/constant;
  - the flag-computation function.
- `core_mul_booth_step` is the single natural sub-module. It is combinational: it takes {acc_hi, multiplier, prev bit} and the multiplicand, and returns the next state after add/sub and arithmetic shift. The parent FSM instantiates it once.

## Test plan
All cases use W=32.
- Unsigned: a=3, b=5, `q_size`=0 → `q_lo`=15, `q_hi`=0, z=0, n=0; `done` high for 1 cycle after edge t+34.
- Signed long: a=0xFFFFFFFE, b=3, `sig`=1, `q_size`=1 → q=0xFFFFFFFF_FFFFFFFA, n=1, z=0.
- Unsigned long MAC: a=b=0xFFFFFFFF, `add`=1, `c_size`=1, c=1 → q=0xFFFFFFFE_00000002; `done` after edge t+35; rerun without the macro → q=0xFFFFFFFE_00000001 at t+34.
- Zero flag: a=0, b=0x1234, `add`=1, `c_size`=0, `c_lo`=0 → q=0, z=1, n=0. Signed MLA with a=0xFFFFFFFF, b=2, `c_lo`=2 → `q_lo`=0, z=1.
- Handshake:
  - pulse `start` mid-operation → ignored, single `done`, result unchanged;
  - `start` held during `done` → second op accepted on that edge.
- Reset mid-op: drop `rst_n` 10 cycles after start → all outputs 0 immediately, no `done`; a fresh op afterwards computes correctly.

Source files
------------

// File: rtl/core_mul_pkg.sv
// Shared types and helpers for the sequential Booth multiply-accumulate unit.
package core_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    // Step counter must hold W+1.
    function automatic int CORE_MUL_CNT_W(input int w);
        return $clog2(w + 2);
    endfunction

    // Returns {z, n} for the selected result width.
    function automatic logic [1:0] mul_flags(
        input logic q_size,
        input logic hi_zero,
        input logic lo_zero,
        input logic hi_msb,
        input logic lo_msb
    );
        logic z;
        logic n;
        z = q_size ? (hi_zero & lo_zero) : lo_zero;
        n = q_size ? hi_msb : lo_msb;
        return {z, n};
    endfunction

endpackage

// File: rtl/core_mul_booth_step.sv
// One radix-2 Booth step: conditional add/sub of the multiplicand into the
// upper accumulator, then a 1-bit arithmetic right shift of the whole chain.
module core_mul_booth_step
    import core_mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W+1:0] acc_hi,
    input  logic [W:0]   mplr,
    input  logic         prev,
    input  logic [W+1:0] mcand,
    output logic [W+1:0] acc_hi_next,
    output logic [W:0]   mplr_next,
    output logic         prev_next
);

    logic [W+1:0] sum;

    always_comb begin
        case ({mplr[0], prev})
            2'b01:   sum = acc_hi + mcand;
            2'b10:   sum = acc_hi - mcand;
            default: sum = acc_hi;
        endcase
    end

    assign acc_hi_next = {sum[W+1], sum[W+1:1]};
    assign mplr_next   = {sum[0], mplr[W:1]};
    assign prev_next   = mplr[0];

endmodule

// File: rtl/core_mul_seq.sv
// Multi-cycle signed/unsigned multiply(-accumulate) with start/done handshake.
// Accumulate support is built only when CORE_MUL_ACC_EN is defined.
module core_mul_seq
    import core_mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c_hi,
    input  logic [W-1:0] c_lo,
    input  logic         c_size,
    input  logic         add,
    input  logic         sig,
    input  logic         q_size,
    output logic [W-1:0] q_hi,
    output logic [W-1:0] q_lo,
    output logic         z,
    output logic         n,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = CORE_MUL_CNT_W(W);

    mul_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [W+1:0]     mcand_reg, acc_hi_reg, acc_hi_next;
    logic [W:0]       mplr_reg, mplr_next;
    logic             prev_reg, prev_next;
    logic             q_size_reg;
    logic [W-1:0]     q_hi_reg, q_lo_reg;
    logic             z_reg, n_reg;
    logic             accept;
    logic [2*W-1:0]   prod, result;
    logic [1:0]       flags;

    // The extra guard bit keeps add/sub of a W+1-bit operand from overflowing.
    logic [W+1:0] a_ext;
    logic [W:0]   b_ext;
    assign a_ext = {{2{sig & a[W-1]}}, a};
    assign b_ext = {sig & b[W-1], b};

    assign accept = start && (state_reg == IDLE || state_reg == DONE);
    assign prod   = {acc_hi_reg[W-2:0], mplr_reg};

`ifdef CORE_MUL_ACC_EN
    logic [W-1:0]   c_upper;
    logic [2*W-1:0] c_reg;
    logic           add_reg;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_c_ext
            assign c_upper[gi] = c_size ? c_hi[gi] : (sig & c_lo[W-1]);
        end
    endgenerate

    assign result = (state_reg == ACC) ? prod + c_reg : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg   <= '0;
            add_reg <= 1'b0;
        end else if (accept) begin
            c_reg   <= {c_upper, c_lo};
            add_reg <= add;
        end
    end
`else
    logic unused_acc_inputs;
    assign unused_acc_inputs = ^{c_hi, c_lo, c_size, add};
    assign result = prod;
`endif

    assign flags = mul_flags(q_size_reg, result[2*W-1:W] == '0, result[W-1:0] == '0,
                             result[2*W-1], result[W-1]);

    core_mul_booth_step #(.W(W)) u_step (
        .acc_hi      (acc_hi_reg),
        .mplr        (mplr_reg),
        .prev        (prev_reg),
        .mcand       (mcand_reg),
        .acc_hi_next (acc_hi_next),
        .mplr_next   (mplr_next),
        .prev_next   (prev_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = MUL;
            MUL: begin
                if (cnt_reg == '0) begin
`ifdef CORE_MUL_ACC_EN
                    state_next = add_reg ? ACC : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            ACC:     state_next = DONE;
            DONE:    state_next = start ? MUL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            acc_hi_reg <= '0;
            mplr_reg   <= '0;
            prev_reg   <= 1'b0;
            q_size_reg <= 1'b0;
            q_hi_reg   <= '0;
            q_lo_reg   <= '0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg    <= CNT_W'(W + 1);
                mcand_reg  <= a_ext;
                acc_hi_reg <= '0;
                mplr_reg   <= b_ext;
                prev_reg   <= 1'b0;
                q_size_reg <= q_size;
            end else if (state_reg == MUL && cnt_reg != '0) begin
                cnt_reg    <= cnt_reg - CNT_W'(1);
                acc_hi_reg <= acc_hi_next;
                mplr_reg   <= mplr_next;
                prev_reg   <= prev_next;
            end
            // Results are captured on the edge that enters DONE so they are
            // stable for the whole done cycle and held until the next one.
            if (state_next == DONE) begin
                q_hi_reg <= q_size_reg ? result[2*W-1:W] : '0;
                q_lo_reg <= result[W-1:0];
                z_reg    <= flags[1];
                n_reg    <= flags[0];
            end
        end
    end

    always_comb begin
        busy = (state_reg == MUL) || (state_reg == ACC);
        done = (state_reg == DONE);
        q_hi = q_hi_reg;
        q_lo = q_lo_reg;
        z    = z_reg;
        n    = n_reg;
    end

endmodule

// File: tb/tb_core_mul_seq.sv
// Directed, table-driven bench for core_mul_seq (W=32), plus handshake and
// reset corner sequences.
module tb_core_mul_seq;
    localparam int W = 32;
`ifdef CORE_MUL_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0, c_hi = '0, c_lo = '0;
    logic         c_size = 1'b0, add = 1'b0, sig = 1'b0, q_size = 1'b0;
    logic [W-1:0] q_hi, q_lo;
    logic         z, n, busy, done;

    always #5 clk = ~clk;

    core_mul_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .c_hi(c_hi), .c_lo(c_lo), .c_size(c_size), .add(add), .sig(sig),
        .q_size(q_size), .q_hi(q_hi), .q_lo(q_lo), .z(z), .n(n),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [W-1:0] a, b, c_hi, c_lo;
        logic         c_size, add, sig, q_size;
        logic [W-1:0] hi_acc, lo_acc;
        logic         z_acc, n_acc;
        logic [W-1:0] hi_mul, lo_mul;
        logic         z_mul, n_mul;
    } vec_t;

    vec_t vecs[12];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(
        input logic [W-1:0] va, vb, vch, vcl, input logic vcs, vadd, vsig, vqs,
        input logic [W-1:0] ha, la, input logic za, na,
        input logic [W-1:0] hm, lm, input logic zm, nm);
        vec_t v;
        v.a = va; v.b = vb; v.c_hi = vch; v.c_lo = vcl;
        v.c_size = vcs; v.add = vadd; v.sig = vsig; v.q_size = vqs;
        v.hi_acc = ha; v.lo_acc = la; v.z_acc = za; v.n_acc = na;
        v.hi_mul = hm; v.lo_mul = lm; v.z_mul = zm; v.n_mul = nm;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; c_hi = v.c_hi; c_lo = v.c_lo;
        c_size = v.c_size; add = v.add; sig = v.sig; q_size = v.q_size;
        start = 1'b1;
    endtask

    // Counts edges after the start edge until done is seen; -1 on timeout.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int exp_lat;
        logic [W-1:0] eh, el;
        logic ez, en;
        eh = ACC_ON ? v.hi_acc : v.hi_mul;
        el = ACC_ON ? v.lo_acc : v.lo_mul;
        ez = ACC_ON ? v.z_acc : v.z_mul;
        en = ACC_ON ? v.n_acc : v.n_mul;
        exp_lat = (ACC_ON && v.add) ? W + 3 : W + 2;
        @(posedge clk); #1;
        drive(v);
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("v%0d busy", idx), 128'(busy), 128'(1'b1));
        wait_done(W + 10, lat);
        check($sformatf("v%0d latency", idx), 128'(lat), 128'(exp_lat));
        check($sformatf("v%0d q_hi", idx), 128'(q_hi), 128'(eh));
        check($sformatf("v%0d q_lo", idx), 128'(q_lo), 128'(el));
        check($sformatf("v%0d z", idx), 128'(z), 128'(ez));
        check($sformatf("v%0d n", idx), 128'(n), 128'(en));
        $display("op %0d: a=%h b=%h sig=%b add=%b q=%h_%h z=%b n=%b lat=%0d",
                 idx, v.a, v.b, v.sig, v.add, q_hi, q_lo, z, n, lat);
        @(posedge clk); #1;
        check($sformatf("v%0d done pulse width", idx), 128'({done, busy}), 128'(2'b00));
    endtask

    initial begin
        int lat;
        int ndone;
        int first;

        vecs[0]  = mk(32'd3, 32'd5, 0, 0, 0, 0, 0, 0, 0, 32'd15, 0, 0, 0, 32'd15, 0, 0);
        vecs[1]  = mk(32'hFFFFFFFE, 32'd3, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1);
        vecs[2]  = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd1, 1, 1, 0, 1, 32'hFFFFFFFE, 32'h2, 0, 1, 32'hFFFFFFFE, 32'h1, 0, 1);
        vecs[3]  = mk(32'd0, 32'h1234, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        vecs[4]  = mk(32'hFFFFFFFF, 32'd2, 0, 32'd2, 0, 1, 1, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFE, 0, 1);
        vecs[5]  = mk(32'd5, 32'd7, 32'hDEADBEEF, 32'hFFFFFFF0, 0, 1, 1, 1, 0, 32'h13, 0, 0, 0, 32'h23, 0, 0);
        vecs[6]  = mk(32'd2, 32'd3, 0, 32'hFFFFFFFF, 0, 1, 0, 1, 32'd1, 32'd5, 0, 0, 0, 32'd6, 0, 0);
        vecs[7]  = mk(32'h80000000, 32'h80000000, 0, 0, 0, 0, 1, 1, 32'h40000000, 0, 0, 0, 32'h40000000, 0, 0, 0);
        vecs[8]  = mk(32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0, 1, 1, 32'hC0000000, 32'h80000000, 0, 1, 32'hC0000000, 32'h80000000, 0, 1);
        vecs[9]  = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 1, 32'hFFFFFFFE, 0, 0, 1, 32'hFFFFFFFE, 32'h1, 0, 1);
        vecs[10] = mk(32'h10000, 32'h10000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        vecs[11] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1, 0, 32'd1, 0, 0, 0, 32'd1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset q_hi", 128'(q_hi), 128'(0));
        check("reset q_lo", 128'(q_lo), 128'(0));
        check("reset flags", 128'({z, n}), 128'(2'b00));
        check("reset busy/done", 128'({busy, done}), 128'(2'b00));
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // start pulsed mid-operation must be ignored
        @(posedge clk); #1;
        drive(vecs[0]);
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                a = 32'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        check("midop done count", 128'(ndone), 128'(1));
        check("midop latency", 128'(first), 128'(W + 2));
        check("midop q_lo", 128'(q_lo), 128'(32'd15));
        $display("op midop-start: q_lo=%h dones=%0d lat=%0d", q_lo, ndone, first);

        // start held during done: back-to-back issue
        @(posedge clk); #1;
        drive(vecs[1]);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(W + 10, lat);
        check("b2b op1 latency", 128'(lat), 128'(W + 2));
        check("b2b op1 q", 128'({q_hi, q_lo}), 128'(64'hFFFFFFFF_FFFFFFFA));
        drive(vecs[0]);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b accept busy/done", 128'({busy, done}), 128'(2'b10));
        wait_done(W + 10, lat);
        check("b2b op2 latency", 128'(lat), 128'(W + 2));
        check("b2b op2 q", 128'({q_hi, q_lo}), 128'(64'd15));
        $display("op back-to-back: q=%h_%h lat=%0d", q_hi, q_lo, lat);
        @(posedge clk); #1;

        // reset mid-operation: immediate clear, no done for the aborted op
        @(posedge clk); #1;
        drive(vecs[11]);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort outputs", 128'({q_hi, q_lo, z, n, busy, done}), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort no done", 128'(ndone), 128'(0));
        $display("op reset-abort: dones after abort=%0d", ndone);
        run_vec(100, vecs[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
